// File: rtl/mips_pkg.sv
// Shared register-file write types and widths for the writeback/regfile boundary.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_wr_req_t;

  typedef enum logic {LAST0, LAST1} rr_state_e;

endpackage

// File: rtl/rf_wr_fifo.sv
// DEPTH-entry synchronous FIFO of register-file write requests.
// Head entry is visible combinationally so the arbiter can pop it the cycle after the push.
module rf_wr_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  rf_wr_req_t din,
  output logic       full,
  input  logic       pop,
  output rf_wr_req_t dout,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // One extra wrap bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  rf_wr_req_t  mem_reg [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Round-robin scheduler of two writeback sources onto the single register-file write port.
// Optional pending-write scoreboard on busy is enabled by defining RF_WR_SCOREBOARD_EN.
module rf_write_scheduler
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [REG_ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [REG_ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] wrReg,
  output logic [DATA_W-1:0]     wrData,
  output logic [NUM_REGS-1:0]   busy
);

  logic       src_valid [2];
  rf_wr_req_t src_req   [2];
  rf_wr_req_t src_dout  [2];
  logic       src_full  [2];
  logic       src_empty [2];
  logic       pop       [2];
  rf_wr_req_t sel_entry;
  logic       any_pop;

  rr_state_e             rr_state_reg;
  logic                  reg_write_reg;
  logic [REG_ADDR_W-1:0] wr_reg_reg;
  logic [DATA_W-1:0]     wr_data_reg;

  assign src_valid[0] = req0_valid;
  assign src_valid[1] = req1_valid;
  assign src_req[0]   = '{addr: req0_addr, data: req0_data};
  assign src_req[1]   = '{addr: req1_addr, data: req1_data};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (src_valid[gi]),
        .din   (src_req[gi]),
        .full  (src_full[gi]),
        .pop   (pop[gi]),
        .dout  (src_dout[gi]),
        .empty (src_empty[gi])
      );
    end
  endgenerate

  assign req0_ready = !src_full[0];
  assign req1_ready = !src_full[1];

  // On a tie, serve the source that was not served last.
  always_comb begin
    pop[0] = 1'b0;
    pop[1] = 1'b0;
    if (!src_empty[0] && (src_empty[1] || rr_state_reg == LAST1)) begin
      pop[0] = 1'b1;
    end else if (!src_empty[1]) begin
      pop[1] = 1'b1;
    end
  end

  assign any_pop   = pop[0] || pop[1];
  assign sel_entry = pop[1] ? src_dout[1] : src_dout[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_state_reg  <= LAST0;
      reg_write_reg <= 1'b0;
      wr_reg_reg    <= '0;
      wr_data_reg   <= '0;
    end else begin
      if (pop[0]) begin
        rr_state_reg <= LAST0;
      end else if (pop[1]) begin
        rr_state_reg <= LAST1;
      end
      // Writes to r0 are drained but never reach the register file.
      reg_write_reg <= any_pop && (sel_entry.addr != '0);
      if (any_pop) begin
        wr_reg_reg  <= sel_entry.addr;
        wr_data_reg <= sel_entry.data;
      end
    end
  end

  assign regWrite = reg_write_reg;
  assign wrReg    = wr_reg_reg;
  assign wrData   = wr_data_reg;

`ifdef RF_WR_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // Clear is applied first so a same-cycle reservation of that register wins.
  always_comb begin
    busy_next = busy_reg;
    if (reg_write_reg) busy_next[wr_reg_reg] = 1'b0;
    if (rsv_valid && rsv_addr != '0) busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_addr};
  assign busy       = '0;
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: per-source expected queues filled on handshake,
// matched against regWrite/wrReg/wrData, plus cycle-exact checks for latency and boundaries.
module tb_rf_write_scheduler;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        regWrite;
  logic [4:0]  wrReg;
  logic [31:0] wrData;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  rf_wr_req_t q0[$];
  rf_wr_req_t q1[$];
  logic [4:0] wr_log[$];
  rf_wr_req_t mon_e;
  int         iss1 = 0;

  rf_write_scheduler #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .regWrite   (regWrite),
    .wrReg      (wrReg),
    .wrData     (wrData),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Output monitor: each issued write must match the head of one source queue.
  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      wr_log.push_back(wrReg);
      if (wrReg[4]) iss1++;
      if (q0.size() > 0 && q0[0].addr == wrReg) begin
        mon_e = q0.pop_front();
        check_val("wr_data_src0", wrData, mon_e.data);
      end else if (q1.size() > 0 && q1[0].addr == wrReg) begin
        mon_e = q1.pop_front();
        check_val("wr_data_src1", wrData, mon_e.data);
      end else begin
        check_val("wr_unexpected", regWrite, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    if (v0 && req0_ready && a0 != 5'd0) q0.push_back('{addr: a0, data: d0});
    if (v1 && req1_ready && a1 != 5'd0) q1.push_back('{addr: a1, data: d1});
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rsv_valid = 1'b0;
    rsv_addr  = 5'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    wr_log.delete();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() + q1.size()) > 0 && n < 50) begin
      tick();
      n++;
    end
    check_val("drain_empty", q0.size() + q1.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] exp2 [8];
    int         acc1;
    int         cur;
    logic       seen;

    reset = 1'b1;
    idle();
    do_reset();
    check_val("rst_regwrite", regWrite, 0);
    check_val("rst_wrreg", wrReg, 0);
    check_val("rst_wrdata", wrData, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready0", req0_ready, 1);
    check_val("rst_ready1", req1_ready, 1);

    // Single write: visible exactly two cycles after the handshake.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
    check_val("t1_lat_t1", regWrite, 0);
    tick();
    check_val("t1_regwrite", regWrite, 1);
    check_val("t1_wrreg", wrReg, 5);
    check_val("t1_wrdata", wrData, 32'hDEADBEEF);
    tick();
    check_val("t1_one_cycle", regWrite, 0);
    wait_drain();

    // Zero register entry is consumed silently; the next entry follows immediately.
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b1, 5'd6, 32'h6666, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
    check_val("t4_r0_no_write", regWrite, 0);
    tick();
    check_val("t4_next_regwrite", regWrite, 1);
    check_val("t4_next_wrreg", wrReg, 6);
    wait_drain();

    // Contention from reset: source 1 wins the first tie.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(1 + i), 32'h1000 + i, 1'b1, 5'(9 + i), 32'h2000 + i);
      tick();
    end
    idle();
    wait_drain();
    exp2 = '{5'd9, 5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4};
    check_val("t2_count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("t2_seq%0d", i), (i < wr_log.size()) ? wr_log[i] : 5'd0, exp2[i]);
    end

    // Backpressure: both sources push every cycle until source 1 fills.
    do_reset();
    iss1 = 0;
    acc1 = 0;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (!req1_ready) begin
        cur = (regWrite && wrReg[4]) ? 1 : 0;
        check_val("t3_full_occupancy", acc1 - iss1 - cur, 4);
        seen = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'hCAFE0005);
        tick();
        idle();
        check_val("t3_pop_same_cycle", regWrite, 1);
      end else begin
        acc1++;
        drive(1'b1, 5'(1 + (i % 14)), 32'h100 + i, 1'b1, 5'(16 + (i % 15)), 32'h200 + i);
        tick();
      end
    end
    check_val("t3_full_seen", seen, 1);
    idle();
    wait_drain();

    // Scoreboard set, clear on issue, and set-wins on collision.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    rsv_valid = 1'b0;
`ifdef RF_WR_SCOREBOARD_EN
    check_val("t5_set", busy[7], 1);
`else
    check_val("t5_off_a", busy, 0);
`endif
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
`ifdef RF_WR_SCOREBOARD_EN
    check_val("t5_hold", busy[7], 1);
`else
    check_val("t5_off_b", busy, 0);
`endif
    tick();
    check_val("t5_wr7", wrReg, 7);
    tick();
`ifdef RF_WR_SCOREBOARD_EN
    check_val("t5_clear", busy[7], 0);
`else
    check_val("t5_off_c", busy, 0);
`endif
    drive(1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
    tick();
    check_val("t5_wr7_again", regWrite, 1);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    rsv_addr = 5'd0;
`ifdef RF_WR_SCOREBOARD_EN
    check_val("t5_set_wins", busy[7], 1);
`else
    check_val("t5_off_d", busy, 0);
`endif
    tick();
    rsv_valid = 1'b0;
    check_val("t5_r0_never_busy", busy[0], 0);
    wait_drain();

    // Reset with three entries buffered discards them.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd20;
    drive(1'b1, 5'd2, 32'hA2, 1'b1, 5'd18, 32'hB2);
    tick();
    rsv_valid = 1'b0;
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd19, 32'hB3);
    tick();
    reset = 1'b1;
    idle();
    tick();
    q0.delete();
    q1.delete();
    check_val("t6_regwrite", regWrite, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_ready0", req0_ready, 1);
    check_val("t6_ready1", req1_ready, 1);
    reset = 1'b0;
    repeat (10) tick();
    check_val("t6_no_stale", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
